// File: rtl/wram_arb_pkg.sv
// Shared definitions for the shared WRAM arbiter: arbitration modes, an
// elaboration-time log2 helper and the window hit compare.
package wram_arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Width used for the window compare; wide enough for AW+1 bits of any
  // practical address so base+size never wraps.
  localparam int WIN_W = 64;

  // Ceiling log2, evaluated at elaboration for widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Unsigned window test with an exclusive upper bound.
  function automatic logic in_window(input logic [WIN_W-1:0] a,
                                     input logic [WIN_W-1:0] base,
                                     input logic [WIN_W-1:0] size);
    return (a >= base) && (a < base + size);
  endfunction

endpackage

// File: rtl/wram_arb_pick.sv
// Combinational winner picker: loader override, then urgent (aged) channels,
// then the base scheme (lowest index or round-robin from rr_ptr).
module wram_arb_pick
  import wram_arb_pkg::*;
#(
  parameter int  NCH    = 2,
  parameter int  MODE   = MODE_FIXED,
  parameter int  OVR_CH = 0,
  localparam int PW     = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic [NCH-1:0] eligible_i,
  input  logic [NCH-1:0] urgent_i,
  input  logic [PW-1:0]  rr_ptr_i,
  input  logic           override_i,
  output logic [PW-1:0]  win_idx_o,
  output logic           win_valid_o
);

  logic [NCH-1:0] urgent_elig;

  assign urgent_elig = urgent_i & eligible_i;

  // Priority resolution; downward loops leave the lowest qualifying index.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    win_valid_o = 1'b0;
    win_idx_o   = '0;
    if (override_i && eligible_i[OVR_CH]) begin
      win_valid_o = 1'b1;
      win_idx_o   = PW'(OVR_CH);
    end else if (MODE == MODE_FIXED) begin
      if (|urgent_elig) begin
        for (int i = NCH - 1; i >= 0; i--) begin
          if (urgent_elig[i]) begin
            win_valid_o = 1'b1;
            win_idx_o   = PW'(i);
          end
        end
      end else begin
        for (int i = NCH - 1; i >= 0; i--) begin
          if (eligible_i[i]) begin
            win_valid_o = 1'b1;
            win_idx_o   = PW'(i);
          end
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (eligible_i[(int'(rr_ptr_i) + k) % NCH]) begin
          win_valid_o = 1'b1;
          win_idx_o   = PW'((int'(rr_ptr_i) + k) % NCH);
        end
      end
    end
  end

endmodule

// File: rtl/shared_wram_arbiter.sv
// Shared WRAM arbiter: NCH requesters, each with its own window onto one
// block RAM, one access granted per cycle. Out-of-window requests report
// hit=0 so the outer mux can route them to SDRAM instead.
module shared_wram_arbiter
  import wram_arb_pkg::*;
#(
  parameter int              NCH        = 2,
  parameter int              AW         = 23,
  parameter int              DW         = 8,
  parameter int              DEPTH      = 8192,
  parameter logic [NCH*AW-1:0] BASE_VEC = {23'h66000, 23'h06000},
  parameter int              MODE       = MODE_FIXED,
  parameter int              STARVE_LIM = 15,
  parameter int              OVR_CH     = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  input  logic              i_override,
  output logic [NCH-1:0]    hit,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic [NCH-1:0]    rvalid,
  output logic              busy
);

  localparam int IW = clog2(DEPTH);
  localparam int PW = (clog2(NCH) < 1) ? 1 : clog2(NCH);
  localparam int CW = clog2(STARVE_LIM + 1);

  logic [IW-1:0]  idx [NCH];
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] urgent;
  logic [NCH-1:0] grant;
  logic [NCH-1:0] ack_q;
  logic [NCH-1:0] rvalid_q;
  logic [DW-1:0]  rdata_q;
  logic [PW-1:0]  rr_q;
  logic [PW-1:0]  win_idx;
  logic           win_valid;
  logic           win_we;
  logic [IW-1:0]  win_addr;
  logic [DW-1:0]  win_wdata;
  logic [CW-1:0]  wait_q [NCH];
  logic [CW-1:0]  wait_d [NCH];
  logic [DW-1:0]  mem [DEPTH];

  // Per-channel window decode and in-window word index.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit[i] = in_window(WIN_W'(addr[i*AW +: AW]), WIN_W'(BASE_VEC[i*AW +: AW]),
                         WIN_W'(DEPTH));
      idx[i] = IW'(addr[i*AW +: AW] - BASE_VEC[i*AW +: AW]);
    end
  end

  // A channel acked this cycle is masked so a held req is not served twice.
  assign eligible = req & hit & ~ack_q;
  assign busy     = |eligible;

  // Aged channels jump the base order (fixed-priority mode only).
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      urgent[i] = (MODE == MODE_FIXED) && (wait_q[i] == CW'(STARVE_LIM));
    end
  end

  wram_arb_pick #(
    .NCH    (NCH),
    .MODE   (MODE),
    .OVR_CH (OVR_CH)
  ) u_pick (
    .eligible_i  (eligible),
    .urgent_i    (urgent),
    .rr_ptr_i    (rr_q),
    .override_i  (i_override),
    .win_idx_o   (win_idx),
    .win_valid_o (win_valid)
  );

  // Steer the winning channel's access onto the single memory port.
  always_comb begin
    grant = '0;
    if (win_valid) grant[win_idx] = 1'b1;
    win_we    = we[win_idx];
    win_addr  = idx[win_idx];
    win_wdata = wdata[win_idx*DW +: DW];
  end

  // Wait counters: count losing cycles, saturate, clear on grant or withdrawal.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wait_d[i] = wait_q[i];
      if (grant[i] || !(req[i] && hit[i])) begin
        wait_d[i] = '0;
      end else if (eligible[i] && (wait_q[i] != CW'(STARVE_LIM))) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
  end

  // Output registers, synchronous read, round-robin pointer and wait counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      rr_q     <= '0;
      for (int i = 0; i < NCH; i++) wait_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ack_q    <= grant;
      rvalid_q <= grant & {NCH{~win_we}};
      if (win_valid && !win_we) rdata_q <= mem[win_addr];
      if ((MODE == MODE_RR) && win_valid) begin
        rr_q <= (win_idx == PW'(NCH - 1)) ? '0 : win_idx + 1'b1;
      end
      for (int i = 0; i < NCH; i++) wait_q[i] <= wait_d[i];
    end
  end

  // Block RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: memory has no reset so it maps to block RAM; contents survive resetn.
    if (win_valid && win_we) mem[win_addr] <= win_wdata;
  end

  assign ack    = ack_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_shared_wram_arbiter.sv
// Bench for shared_wram_arbiter: three instances (fixed priority, round-robin
// with override on ch1, three-channel fixed priority for aging) share one
// stimulus and are compared each cycle against a behavioural model.
module tb_shared_wram_arbiter;

  localparam int DEPTH = 8192;
  localparam int LIM   = 15;
  localparam int ND    = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [22:0] a [3];
  logic [7:0]  wd [3];
  logic        ovr = 1'b0;

  logic [1:0] hit_f, ack_f, rv_f, hit_r, ack_r, rv_r;
  logic [2:0] hit_a, ack_a, rv_a;
  logic [7:0] rd_f, rd_r, rd_a;
  logic       busy_f, busy_r, busy_a;

  wire [2:0] hit_o [3];
  wire [2:0] ack_o [3];
  wire [2:0] rv_o  [3];
  wire [7:0] rd_o  [3];
  wire       busy_o [3];

  assign hit_o[0] = {1'b0, hit_f};
  assign hit_o[1] = {1'b0, hit_r};
  assign hit_o[2] = hit_a;
  assign ack_o[0] = {1'b0, ack_f};
  assign ack_o[1] = {1'b0, ack_r};
  assign ack_o[2] = ack_a;
  assign rv_o[0]  = {1'b0, rv_f};
  assign rv_o[1]  = {1'b0, rv_r};
  assign rv_o[2]  = rv_a;
  assign rd_o[0]  = rd_f;
  assign rd_o[1]  = rd_r;
  assign rd_o[2]  = rd_a;
  assign busy_o[0] = busy_f;
  assign busy_o[1] = busy_r;
  assign busy_o[2] = busy_a;

  always #5 clk = ~clk;

  shared_wram_arbiter #(.NCH(2), .MODE(0), .OVR_CH(0), .STARVE_LIM(LIM)) u_fix (
    .clk(clk), .resetn(resetn), .req(req[1:0]), .we(we[1:0]), .addr({a[1], a[0]}),
    .wdata({wd[1], wd[0]}), .i_override(ovr), .hit(hit_f), .ack(ack_f),
    .rdata(rd_f), .rvalid(rv_f), .busy(busy_f));

  shared_wram_arbiter #(.NCH(2), .MODE(1), .OVR_CH(1), .STARVE_LIM(LIM)) u_rr (
    .clk(clk), .resetn(resetn), .req(req[1:0]), .we(we[1:0]), .addr({a[1], a[0]}),
    .wdata({wd[1], wd[0]}), .i_override(ovr), .hit(hit_r), .ack(ack_r),
    .rdata(rd_r), .rvalid(rv_r), .busy(busy_r));

  shared_wram_arbiter #(.NCH(3), .BASE_VEC({23'h10000, 23'h66000, 23'h06000}),
                        .MODE(0), .OVR_CH(0), .STARVE_LIM(LIM)) u_age (
    .clk(clk), .resetn(resetn), .req(req), .we(we), .addr({a[2], a[1], a[0]}),
    .wdata({wd[2], wd[1], wd[0]}), .i_override(ovr), .hit(hit_a), .ack(ack_a),
    .rdata(rd_a), .rvalid(rv_a), .busy(busy_a));

  // Reference model state, one set per instance.
  int         bases [3]  = '{32'h06000, 32'h66000, 32'h10000};
  int         nch_of [3] = '{2, 2, 3};
  int         mode_of [3] = '{0, 1, 0};
  int         ovr_of [3] = '{0, 1, 0};
  logic [7:0] mmem [3][DEPTH];
  bit         mknown [3][DEPTH];
  int         m_ack [3];
  int         m_rr [3];
  logic [7:0] m_rd [3];
  bit         m_rk [3];
  int         m_wait [3][3];

  int n_cmp = 0;
  int n_err = 0;
  int age_last, age_gap, age_hits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_win(int ch, logic [22:0] ad);
    return (int'(ad) >= bases[ch]) && (int'(ad) < bases[ch] + DEPTH);
  endfunction

  // Winner per the arbitration rules: override, urgent, then base order list.
  function automatic int pick(int d, int el);
    int n;
    int order[$];
    n = nch_of[d];
    if (ovr && (((el >> ovr_of[d]) & 1) != 0)) return ovr_of[d];
    if (mode_of[d] == 0) begin
      for (int ch = 0; ch < n; ch++)
        if ((((el >> ch) & 1) != 0) && m_wait[d][ch] == LIM) return ch;
      for (int ch = 0; ch < n; ch++) order.push_back(ch);
    end else begin
      for (int k = 0; k < n; k++) order.push_back((m_rr[d] + k) % n);
    end
    foreach (order[j]) if (((el >> order[j]) & 1) != 0) return order[j];
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_ack[d] = 0;
      m_rr[d]  = 0;
      m_rd[d]  = 8'h00;
      m_rk[d]  = 1'b1;
      for (int ch = 0; ch < 3; ch++) m_wait[d][ch] = 0;
    end
  endtask

  // One arbitration cycle: check decode/busy, advance the model, clock, check outputs.
  task automatic do_cycle(input string tag);
    int exp_ack [3];
    int exp_rv [3];
    int n, hv, el, w, off;
    #1;
    for (int d = 0; d < ND; d++) begin
      n  = nch_of[d];
      hv = 0;
      for (int ch = 0; ch < n; ch++) if (in_win(ch, a[ch])) hv |= (1 << ch);
      check($sformatf("%s.hit%0d", tag, d), 32'(hit_o[d]), hv);
      el = 0;
      for (int ch = 0; ch < n; ch++)
        if (req[ch] && (((hv >> ch) & 1) != 0) && (((m_ack[d] >> ch) & 1) == 0)) el |= (1 << ch);
      check($sformatf("%s.busy%0d", tag, d), 32'(busy_o[d]), 32'(el != 0));
      w = pick(d, el);
      for (int ch = 0; ch < n; ch++) begin
        if (ch == w || !(req[ch] && in_win(ch, a[ch]))) m_wait[d][ch] = 0;
        else if ((((el >> ch) & 1) != 0) && m_wait[d][ch] < LIM) m_wait[d][ch]++;
      end
      exp_ack[d] = 0;
      exp_rv[d]  = 0;
      if (w >= 0) begin
        off = int'(a[w]) - bases[w];
        exp_ack[d] = 1 << w;
        if (we[w]) begin
          mmem[d][off]   = wd[w];
          mknown[d][off] = 1'b1;
        end else begin
          exp_rv[d] = 1 << w;
          m_rd[d]   = mmem[d][off];
          m_rk[d]   = mknown[d][off];
        end
        if (mode_of[d] == 1) m_rr[d] = (w == n - 1) ? 0 : w + 1;
      end
      m_ack[d] = exp_ack[d];
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s.ack%0d", tag, d), 32'(ack_o[d]), exp_ack[d]);
      check($sformatf("%s.rvalid%0d", tag, d), 32'(rv_o[d]), exp_rv[d]);
      if (m_rk[d]) check($sformatf("%s.rdata%0d", tag, d), 32'(rd_o[d]), 32'(m_rd[d]));
    end
  endtask

  task automatic set_ch(input int ch, input bit r, input bit w,
                        input logic [22:0] ad, input logic [7:0] dat);
    req[ch] = r;
    we[ch]  = w;
    a[ch]   = ad;
    wd[ch]  = dat;
  endtask

  function automatic logic [22:0] rand_addr(int ch);
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 23'($urandom);
      1:       return 23'(bases[ch] - 1);
      2:       return 23'(bases[ch] + DEPTH);
      3:       return 23'(bases[ch] + DEPTH - 1);
      default: return 23'(bases[ch] + int'($urandom_range(0, 15)));
    endcase
  endfunction

  initial begin
    for (int ch = 0; ch < 3; ch++) begin
      a[ch]  = 23'(bases[ch]);
      wd[ch] = 8'h00;
    end
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst.ack%0d", d), 32'(ack_o[d]), 0);
      check($sformatf("rst.rvalid%0d", d), 32'(rv_o[d]), 0);
      check($sformatf("rst.rdata%0d", d), 32'(rd_o[d]), 0);
    end
    @(negedge clk);
    resetn = 1'b1;

    // Ch0 writes through its window, ch1 reads the same word through its own.
    req = '0; set_ch(0, 1, 1, 23'h06005, 8'hA5); do_cycle("wr");
    check("wr.ack_fix", 32'(ack_f), 1);
    req = '0; set_ch(1, 1, 0, 23'h66005, 8'h00); do_cycle("rd");
    check("rd.ack_fix", 32'(ack_f), 2);
    check("rd.rvalid_fix", 32'(rv_f), 2);
    check("rd.rdata_fix", 32'(rd_f), 32'h A5);
    req = '0; do_cycle("idle");

    // Continuous requests: alternation by masking, aging rescues ch2 on u_age.
    set_ch(0, 1, 0, 23'h06005, 8'h00);
    set_ch(1, 1, 0, 23'h66005, 8'h00);
    set_ch(2, 1, 0, 23'h10003, 8'h00);
    age_last = -1; age_gap = 0; age_hits = 0;
    for (int k = 0; k < 60; k++) begin
      do_cycle("cont");
      if (ack_a[2]) begin
        if (k - age_last > age_gap) age_gap = k - age_last;
        age_last = k;
        age_hits++;
      end
    end
    check("age.gap_within_limit", 32'(age_gap <= LIM + 2), 1);
    check("age.hits", 32'(age_hits >= 3), 1);

    // Loader override, then release.
    req[2] = 1'b0;
    ovr = 1'b1;
    for (int k = 0; k < 6; k++) do_cycle("ovr");
    ovr = 1'b0;
    for (int k = 0; k < 3; k++) do_cycle("ovr_off");
    req = '0; do_cycle("idle");

    // Window boundaries on ch0.
    set_ch(0, 1, 1, 23'h06000, 8'h11); do_cycle("bnd.w6000");
    req = '0; do_cycle("idle");
    set_ch(0, 1, 1, 23'h05FFF, 8'h44); do_cycle("bnd.w5fff");
    check("bnd.noack_5fff", 32'(ack_f), 0);
    set_ch(0, 1, 1, 23'h08000, 8'h22); do_cycle("bnd.w8000");
    check("bnd.noack_8000", 32'(ack_f), 0);
    set_ch(0, 1, 0, 23'h06000, 8'h00); do_cycle("bnd.r6000");
    check("bnd.rdata_6000", 32'(rd_f), 32'h11);
    req = '0; do_cycle("idle");
    set_ch(0, 1, 1, 23'h07FFF, 8'h33); do_cycle("bnd.w7fff");
    req = '0; do_cycle("idle");
    set_ch(0, 1, 0, 23'h07FFF, 8'h00); do_cycle("bnd.r7fff");
    check("bnd.rdata_7fff", 32'(rd_f), 32'h33);
    req = '0; do_cycle("idle");

    // Reset right after a read grant; memory must survive.
    set_ch(0, 1, 0, 23'h06005, 8'h00); do_cycle("pre_rst");
    check("pre_rst.rvalid_fix", 32'(rv_f), 1);
    resetn = 1'b0;
    req = '0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("mid_rst.ack%0d", d), 32'(ack_o[d]), 0);
      check($sformatf("mid_rst.rvalid%0d", d), 32'(rv_o[d]), 0);
      check($sformatf("mid_rst.rdata%0d", d), 32'(rd_o[d]), 0);
    end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    set_ch(0, 1, 0, 23'h06005, 8'h00); do_cycle("post_rst");
    check("post_rst.rdata_fix", 32'(rd_f), 32'hA5);
    req = '0; do_cycle("idle");

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int ch = 0; ch < 3; ch++)
        set_ch(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               rand_addr(ch), 8'($urandom));
      ovr = ($urandom_range(0, 7) == 0);
      do_cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shared_wram_arbiter.md
Name: shared_wram_arbiter

Overview:
- Parametrised successor to the two-port WRAM BSRAM share in the SDRAM arbiter path.
- NCH requesters each see one BSRAM-backed window at its own base address; the block arbitrates one access per cycle.
- Requesters are e.g. NES CPU at 0x6000 and RV at 0x66000; arbitration is fixed-priority-with-aging or round-robin, with a loader override.
- Requests outside a channel's window are not serviced here; hit=0 tells the outer mux to route that access to sdram_nes.

Parameters:
NCH, 2, number of requesting channels (2..8)
AW, 23, request address width
DW, 8, data width
DEPTH, 8192, window size in words; power of two
BASE_VEC, {23'h66000, 23'h06000}, packed NCH*AW per-channel window base; channel i in bits [i*AW +: AW]
MODE, 0, 0 = fixed priority with aging, 1 = round-robin
STARVE_LIM, 15, cycles of waiting before a channel becomes urgent (MODE 0 only)
OVR_CH, 0, channel given absolute priority while i_override=1

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req  in  NCH  per-channel request level; held until ack
we  in  NCH  1 = write, 0 = read; valid with req
addr  in  NCH*AW  per-channel address
wdata  in  NCH*DW  per-channel write data
i_override  in  1  loader in progress: OVR_CH wins every arbitration
hit  out  NCH  combinational: addr[i] inside window i
ack  out  NCH  one-hot registered pulse: request accepted and performed
rdata  out  DW  shared read data bus
rvalid  out  NCH  rdata belongs to channel i this cycle (read ack)
busy  out  1  any req&hit channel not acked this cycle

Behaviour:
- Window decode:
  - hit[i] = (addr[i] >= BASE[i]) && (addr[i] < BASE[i]+DEPTH), using an unsigned compare with AW+1 bits; the upper bound is exclusive.
  - Index = (addr[i]-BASE[i]) truncated to clog2(DEPTH) bits.
- Eligibility: eligible[i] = req[i] & hit[i] & ~ack[i]. A channel acked this cycle is masked, so a held req is not serviced twice.
- Winner priority, highest to lowest:
  1. OVR_CH, when i_override=1 and it is eligible.
  2. Urgent channels (MODE 0), lowest index first.
  3. Base scheme among the rest:
     - MODE 0: lowest index wins.
     - MODE 1: first eligible at or after rr_ptr, wrapping at NCH-1 -> 0.
- Exactly one winner or none per cycle.
- At posedge with winner w:
  - If we[w]=1: mem[idx_w] <= wdata[w]; rdata unchanged.
  - If we[w]=0: rdata <= mem[idx_w].
  - ack <= onehot(w); rvalid <= onehot(w) & ~we[w].
  - MODE 1: rr_ptr <= (w==NCH-1) ? 0 : w+1.
- With no winner: ack <= 0, rvalid <= 0, rdata holds.
- Latency: req in cycle N -> ack, and rdata/rvalid for reads, in cycle N+1. Throughput is 1 access/cycle total.
- rdata holds its last read value until the next read grant.
- Requester protocol: deassert req, or present the next access, in the ack cycle. A req still high after ack is treated as a new request in the following cycle.
- Write followed by read to the same index in the next grant returns the new data. There is no same-cycle conflict because there is only one grant per cycle.
- Aging (MODE 0):
  - wait_cnt[i] increments, saturating at STARVE_LIM, while eligible[i] and not granted.
  - It clears on grant or when req[i]&hit[i] drops.
  - urgent[i] = (wait_cnt[i]==STARVE_LIM).
- Out-of-window req (hit=0): never acked, no memory effect, not counted in busy.
- Reset (async assert, sync deassert is the system's responsibility):
  - ack=0, rvalid=0, rdata=0, rr_ptr=0, wait_cnt=0.
  - Memory contents are not reset. A request in flight at reset is dropped and must be re-presented.
- i_override toggling mid-stream: takes effect at the next arbitration. It does not abort an ack already issued.

Decomposition:
- Package wram_arb_pkg:
  - MODE_FIXED=0, MODE_RR=1.
  - clog2 function.
  - Window base/size helper function for the hit compare.
- Sub-module wram_arb_pick: combinational picker (eligible, urgent, rr_ptr, override, mode -> winner index + valid). The top keeps the memory, counters, pointer and output registers.
- Memory is inferred as block RAM: one write port, one synchronous read port.

Test Plan:
- Ch0 write addr 0x6005 = 0xA5; next cycle ch1 read addr 0x66005 -> ack[0] at N+1, then ack[1] and rvalid[1] with rdata=0xA5.
- Both channels read every cycle, MODE 0 -> ch0 acked each cycle at most on alternate cycles due to masking. Ch1 is acked at least once every STARVE_LIM+2 cycles via aging.
- MODE 1, both channels continuously requesting -> acks alternate 0,1,0,1. rr_ptr wraps from NCH-1 to 0.
- i_override=1, OVR_CH=1, both requesting -> ch1 wins every eligible cycle. Deasserting override restores the base order the next cycle.
- Boundary: ch0 addr 0x5FFF and 0x8000 -> hit=0, no ack, memory unchanged. Addr 0x7FFF -> hit=1, index 0x1FFF.
- Reset asserted the cycle after a read grant -> ack/rvalid/rdata immediately 0. After release, memory contents are intact and a re-issued read returns the prior data.
